// File: rtl/version_store_ctrl_if.sv
// Request/response bundle for version_store_ctrl.
// master = front-end side, slave = store controller side.
interface version_store_ctrl_if #(
    parameter int DATA_WIDTH    = 32,
    parameter int VERSION_WIDTH = 4,
    parameter int VERSION_NUM   = 4
);
    localparam int OW = $clog2(VERSION_NUM + 1);

    logic                     wrValid;
    logic                     wrReady;
    logic [VERSION_WIDTH-1:0] wrVersion;
    logic [DATA_WIDTH-1:0]    wrData;
    logic                     rdValid;
    logic                     rdReady;
    logic [VERSION_WIDTH-1:0] rdVersion;
    logic                     rspValid;
    logic                     rspReady;
    logic [DATA_WIDTH-1:0]    rspData;
    logic [VERSION_WIDTH-1:0] rspVersion;
    logic                     rspHit;
    logic                     wrDropped;
    logic [OW-1:0]            occupancy;

    modport master (
        output wrValid, wrVersion, wrData, rdValid, rdVersion, rspReady,
        input  wrReady, rdReady, rspValid, rspData, rspVersion, rspHit,
               wrDropped, occupancy
    );

    modport slave (
        input  wrValid, wrVersion, wrData, rdValid, rdVersion, rspReady,
        output wrReady, rdReady, rspValid, rspData, rspVersion, rspHit,
               wrDropped, occupancy
    );
endinterface

// File: rtl/version_store_ctrl.sv
// Multi-version value store: VERSION_NUM (tag, data) slots, a write port that
// overwrites / allocates / evicts-oldest, and a read port returning the newest
// version strictly below the requested tag.
// Optional: VERSION_STORE_WRITE_PRIORITY_EN makes writes win every conflict
// instead of round-robin.
module version_store_ctrl #(
    parameter int DATA_WIDTH    = 32,
    parameter int VERSION_WIDTH = 4,
    parameter int VERSION_NUM   = 4
) (
    input logic                clk,
    input logic                rst,
    version_store_ctrl_if.slave bus
);
    localparam int OW = $clog2(VERSION_NUM + 1);
    localparam int IW = $clog2(VERSION_NUM);

    typedef enum logic [1:0] {IDLE, WRITE, READ, RESP} state_t;

    state_t state_q, state_d;

    logic [VERSION_NUM-1:0]                    slot_vld;
    logic [VERSION_NUM-1:0][VERSION_WIDTH-1:0] slot_tag;
    logic [VERSION_NUM-1:0][DATA_WIDTH-1:0]    slot_data;
    logic [OW-1:0]                             occ_q;

    logic                     last_grant_wr;  // 0 = read won last, 1 = write
    logic [VERSION_WIDTH-1:0] req_ver;
    logic [DATA_WIDTH-1:0]    req_data;

    logic                     rsp_hit_q;
    logic [VERSION_WIDTH-1:0] rsp_ver_q;
    logic [DATA_WIDTH-1:0]    rsp_data_q;

    logic grant_wr, grant_rd, wr_hs, rd_hs;

    logic                     match_hit, free_hit, best_hit;
    logic [IW-1:0]            match_idx, free_idx, min_idx, best_idx;
    logic [VERSION_WIDTH-1:0] min_tag, best_tag;

    // Arbitration: lone requester wins; on conflict alternate (or write wins)
    always_comb begin
        grant_wr = 1'b0;
        grant_rd = 1'b0;
        if (state_q == IDLE && !rst) begin
            if (bus.wrValid && bus.rdValid) begin
`ifdef VERSION_STORE_WRITE_PRIORITY_EN
                grant_wr = 1'b1;
`else
                grant_wr = !last_grant_wr;
                grant_rd = last_grant_wr;
`endif
            end else begin
                grant_wr = bus.wrValid;
                grant_rd = bus.rdValid;
            end
        end
    end

    assign wr_hs = grant_wr && bus.wrValid;
    assign rd_hs = grant_rd && bus.rdValid;

    // Write slot search: tag match, lowest free slot, smallest-tag victim
    always_comb begin
        match_hit = 1'b0;
        match_idx = '0;
        free_hit  = 1'b0;
        free_idx  = '0;
        min_idx   = '0;
        min_tag   = slot_tag[0];
        for (int i = 0; i < VERSION_NUM; i++) begin
            if (slot_vld[i] && slot_tag[i] == req_ver && !match_hit) begin
                match_hit = 1'b1;
                match_idx = IW'(i);
            end
            if (!slot_vld[i] && !free_hit) begin
                free_hit = 1'b1;
                free_idx = IW'(i);
            end
            // strict compare keeps the lowest index on ties
            if (slot_tag[i] < min_tag) begin
                min_tag = slot_tag[i];
                min_idx = IW'(i);
            end
        end
    end

    // Read search: greatest nonzero valid tag strictly below the request
    always_comb begin
        best_hit = 1'b0;
        best_idx = '0;
        best_tag = '0;
        for (int i = 0; i < VERSION_NUM; i++) begin
            if (slot_vld[i] && slot_tag[i] != '0 && slot_tag[i] < req_ver &&
                (!best_hit || slot_tag[i] > best_tag)) begin
                best_hit = 1'b1;
                best_idx = IW'(i);
                best_tag = slot_tag[i];
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (wr_hs) state_d = WRITE;
                   else if (rd_hs) state_d = READ;
            WRITE: state_d = IDLE;
            READ:  state_d = RESP;
            RESP:  if (bus.rspReady) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register, request latch and arbitration history
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            last_grant_wr <= 1'b0;
            req_ver       <= '0;
            req_data      <= '0;
        end else begin
            state_q <= state_d;
            if (wr_hs) begin
                last_grant_wr <= 1'b1;
                req_ver       <= bus.wrVersion;
                req_data      <= bus.wrData;
            end else if (rd_hs) begin
                last_grant_wr <= 1'b0;
                req_ver       <= bus.rdVersion;
            end
        end
    end

    // Slot storage update in WRITE; zero tags are discarded
    always_ff @(posedge clk) begin
        if (rst) begin
            slot_vld  <= '0;
            slot_tag  <= '0;
            slot_data <= '0;
            occ_q     <= '0;
        end else if (state_q == WRITE && req_ver != '0) begin
            if (match_hit) begin
                slot_data[match_idx] <= req_data;
            end else if (free_hit) begin
                slot_vld[free_idx]  <= 1'b1;
                slot_tag[free_idx]  <= req_ver;
                slot_data[free_idx] <= req_data;
                occ_q               <= occ_q + 1'b1;
            end else begin
                slot_tag[min_idx]  <= req_ver;
                slot_data[min_idx] <= req_data;
            end
        end
    end

    // Response register captured at the end of READ, held through RESP
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_hit_q  <= 1'b0;
            rsp_ver_q  <= '0;
            rsp_data_q <= '0;
        end else if (state_q == READ) begin
            rsp_hit_q  <= best_hit;
            rsp_ver_q  <= best_hit ? best_tag : '0;
            rsp_data_q <= best_hit ? slot_data[best_idx] : '0;
        end
    end

    assign bus.wrReady    = grant_wr;
    assign bus.rdReady    = grant_rd;
    assign bus.rspValid   = (state_q == RESP) && !rst;
    assign bus.rspData    = rsp_data_q;
    assign bus.rspVersion = rsp_ver_q;
    assign bus.rspHit     = rsp_hit_q;
    assign bus.wrDropped  = (state_q == WRITE) && (req_ver == '0) && !rst;
    assign bus.occupancy  = occ_q;
endmodule

// File: tb/tb_version_store_ctrl.sv
// Directed bench for version_store_ctrl with a response scoreboard.
module tb_version_store_ctrl;
    localparam int DW = 32;
    localparam int VW = 4;
    localparam int VN = 4;

    typedef struct packed {
        logic          hit;
        logic [VW-1:0] ver;
        logic [DW-1:0] data;
    } rsp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    rsp_t exp_q[$];

    version_store_ctrl_if #(.DATA_WIDTH(DW), .VERSION_WIDTH(VW), .VERSION_NUM(VN)) vif ();

    version_store_ctrl #(.DATA_WIDTH(DW), .VERSION_WIDTH(VW), .VERSION_NUM(VN)) dut (
        .clk (clk),
        .rst (rst),
        .bus (vif)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: compare every consumed response against the scoreboard
    always @(negedge clk) begin
        if (!rst && vif.rspValid && vif.rspReady) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp: got response ver %0h with empty scoreboard", vif.rspVersion);
            end else begin
                rsp_t e;
                e = exp_q.pop_front();
                chk("rsp_hit",  64'(vif.rspHit),     64'(e.hit));
                chk("rsp_ver",  64'(vif.rspVersion), 64'(e.ver));
                chk("rsp_data", 64'(vif.rspData),    64'(e.data));
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_wrReady",   64'(vif.wrReady),   64'd0);
        chk("rst_rdReady",   64'(vif.rdReady),   64'd0);
        chk("rst_rspValid",  64'(vif.rspValid),  64'd0);
        chk("rst_occupancy", 64'(vif.occupancy), 64'd0);
        chk("rst_wrDropped", 64'(vif.wrDropped), 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Issue one write; checks the wrDropped flag in the WRITE cycle
    task automatic do_write(input logic [VW-1:0] v, input logic [DW-1:0] d);
        int n = 0;
        vif.wrValid = 1'b1; vif.wrVersion = v; vif.wrData = d;
        forever begin
            @(negedge clk);
            if (vif.wrReady) break;
            if (++n > 50) begin
                chk("wr_timeout", 64'd1, 64'd0);
                vif.wrValid = 1'b0;
                return;
            end
        end
        @(posedge clk);
        #1 vif.wrValid = 1'b0; vif.wrVersion = '1; vif.wrData = '1;
        @(negedge clk);
        chk("wrDropped", 64'(vif.wrDropped), 64'(v == '0));
        @(posedge clk);
        #1;
    endtask

    // Issue one read, push its expected response, check N+1/N+2 latency
    task automatic do_read(input logic [VW-1:0] v, input logic h,
                           input logic [VW-1:0] ev, input logic [DW-1:0] ed);
        int n = 0;
        vif.rdValid = 1'b1; vif.rdVersion = v;
        forever begin
            @(negedge clk);
            if (vif.rdReady) break;
            if (++n > 50) begin
                chk("rd_timeout", 64'd1, 64'd0);
                vif.rdValid = 1'b0;
                return;
            end
        end
        exp_q.push_back('{hit: h, ver: ev, data: ed});
        @(posedge clk);
        #1 vif.rdValid = 1'b0; vif.rdVersion = '0;
        @(negedge clk);
        chk("rd_lat_n1", 64'(vif.rspValid), 64'd0);
        @(negedge clk);
        chk("rd_lat_n2", 64'(vif.rspValid), 64'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] seq, seq_exp;
        int g;
        vif.wrValid = 0; vif.wrVersion = 0; vif.wrData = 0;
        vif.rdValid = 0; vif.rdVersion = 0; vif.rspReady = 1;

        // Empty store misses
        do_reset();
        do_read(4'd5, 1'b0, 4'd0, 32'h0);
        chk("occ_empty", 64'(vif.occupancy), 64'd0);

        // Greatest-below selection
        do_write(4'd2, 32'hA);
        do_write(4'd4, 32'hB);
        do_write(4'd7, 32'hC);
        do_read(4'd7, 1'b1, 4'd4, 32'hB);
        do_read(4'd8, 1'b1, 4'd7, 32'hC);
        do_read(4'd2, 1'b0, 4'd0, 32'h0);
        do_read(4'd1, 1'b0, 4'd0, 32'h0);
        chk("occ_three", 64'(vif.occupancy), 64'd3);

        // Eviction of the smallest tag when full
        do_reset();
        do_write(4'd3, 32'h3);
        do_write(4'd5, 32'h5);
        do_write(4'd6, 32'h6);
        do_write(4'd9, 32'h9);
        do_write(4'd8, 32'hD);
        chk("occ_full", 64'(vif.occupancy), 64'd4);
        do_read(4'd9, 1'b1, 4'd8, 32'hD);
        do_read(4'd4, 1'b0, 4'd0, 32'h0);
        do_read(4'd15, 1'b1, 4'd9, 32'h9);

        // Overwrite and zero-tag drop
        do_reset();
        do_write(4'd5, 32'h1);
        do_write(4'd5, 32'h2);
        chk("occ_overwrite", 64'(vif.occupancy), 64'd1);
        do_read(4'd6, 1'b1, 4'd5, 32'h2);
        do_write(4'd0, 32'hEE);
        chk("occ_drop", 64'(vif.occupancy), 64'd1);
        do_read(4'd15, 1'b1, 4'd5, 32'h2);

        // Both requesters held from reset: observe grant order
        vif.wrValid = 1; vif.wrVersion = 4'd3; vif.wrData = 32'h33;
        vif.rdValid = 1; vif.rdVersion = 4'd4;
        do_reset();
        seq = '0;
        g = 0;
        for (int cyc = 0; cyc < 60 && g < 4; cyc++) begin
            @(negedge clk);
            if (vif.wrValid && vif.wrReady) begin
                seq[g] = 1'b1; g++;
            end else if (vif.rdValid && vif.rdReady) begin
                seq[g] = 1'b0; g++;
                exp_q.push_back('{hit: 1'b1, ver: 4'd3, data: 32'h33});
            end
        end
        @(posedge clk);
        #1 vif.wrValid = 0; vif.rdValid = 0;
`ifdef VERSION_STORE_WRITE_PRIORITY_EN
        seq_exp = 4'b1111;
`else
        seq_exp = 4'b0101;
`endif
        chk("grant_count", 64'(g), 64'd4);
        chk("grant_seq", 64'(seq), 64'(seq_exp));
        repeat (4) @(posedge clk);
        #1;

        // Backpressure: response held stable, no new grant
        vif.rspReady = 0;
        do_read(4'd9, 1'b1, 4'd3, 32'h33);
        vif.rdValid = 1; vif.rdVersion = 4'd2; vif.wrValid = 1; vif.wrVersion = 4'd6;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("hold_valid",  64'(vif.rspValid),   64'd1);
            chk("hold_ver",    64'(vif.rspVersion), 64'd3);
            chk("hold_data",   64'(vif.rspData),    64'h33);
            chk("hold_nogrant", 64'({vif.wrReady, vif.rdReady}), 64'd0);
        end
        @(posedge clk);
        #1 vif.rdValid = 0; vif.wrValid = 0; vif.rspReady = 1;
        @(posedge clk);
        #1;

        // Reset while a response is pending
        do_reset();
        do_write(4'd2, 32'h77);
        vif.rspReady = 0;
        do_read(4'd5, 1'b1, 4'd2, 32'h77);
        rst = 1;
        @(negedge clk);
        chk("rstmid_rspValid",  64'(vif.rspValid),  64'd0);
        @(posedge clk);
        @(negedge clk);
        chk("rstmid_occupancy", 64'(vif.occupancy), 64'd0);
        exp_q.delete();
        @(posedge clk);
        #1 rst = 0; vif.rspReady = 1;
        do_read(4'd5, 1'b0, 4'd0, 32'h0);

        repeat (4) @(posedge clk);
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
